// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M-style multiply/divide unit, one bit per cycle.
// Ports: Clk, Reset (async, active-high), start/op/a/b in; busy/done/result out.
module muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next;

  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] ma_q;
  logic [WIDTH-1:0] mb_q;
  logic             neg_q;
  logic             rneg_q;
  logic             dz_q;
  // mul: {high accumulator, multiplier}; div: low half is the quotient
  logic [W2-1:0]    p;
  logic [WIDTH-1:0] rem;

  logic             accept;
  logic             is_div;
  logic             sa;
  logic             sb;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic             a_zero;
  logic             b_zero;
  logic             skip;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (op)
      3'd1, 3'd4, 3'd6: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      3'd2: sa = 1'b1;
      default: ;
    endcase
  end

  assign is_div = op[2];
  assign neg_a  = sa & a[WIDTH-1];
  assign neg_b  = sb & b[WIDTH-1];
  assign ma     = neg_a ? -a : a;
  assign mb     = neg_b ? -b : b;
  assign a_zero = (a == '0);
  assign b_zero = (b == '0);
  // divide-by-zero and zero-operand multiply bypass the iterations
  assign skip   = is_div ? b_zero
                         : (EARLY_ZERO && (a_zero || b_zero));
  assign accept = (state == IDLE) && start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = IDLE;
    unique case (state)
      IDLE:  next = start ? (skip ? FIXUP : CALC) : IDLE;
      CALC:  next = (cnt == '0) ? FIXUP : CALC;
      FIXUP: next = DONE;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    full;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] fix_val;

  assign acc  = {1'b0, p[W2-1:WIDTH]}
              + (p[0] ? {1'b0, ma_q} : '0);
  assign sh   = {rem, p[WIDTH-1]};
  assign diff = sh - {1'b0, mb_q};

  always_comb begin
    full    = neg_q ? -p : p;
    quo     = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rs      = rneg_q ? -rem : rem;
    fix_val = '0;
    if (op_q[2]) begin
      if (dz_q) fix_val = op_q[1] ? a_q : '1;
      else      fix_val = op_q[1] ? rs : quo;
    end else begin
      fix_val = (op_q[1:0] == 2'd0) ? full[WIDTH-1:0]
                                    : full[W2-1:WIDTH];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      p      <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt    <= CW'(WIDTH - 1);
        op_q   <= op;
        a_q    <= a;
        ma_q   <= ma;
        mb_q   <= mb;
        neg_q  <= neg_a ^ neg_b;
        rneg_q <= neg_a;
        dz_q   <= is_div && b_zero;
        rem    <= '0;
        if (is_div)    p <= {{WIDTH{1'b0}}, ma};
        else if (skip) p <= '0;
        else           p <= {{WIDTH{1'b0}}, mb};
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        if (op_q[2]) begin
          // restoring step: keep the trial difference if it did not borrow
          if (!diff[WIDTH]) rem <= diff[WIDTH-1:0];
          else              rem <= sh[WIDTH-1:0];
          p[WIDTH-1:0] <= {p[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          p <= {acc, p[WIDTH-1:1]};
        end
      end
      if (state == FIXUP) result <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: random + directed bench for muldiv_iter (WIDTH=32),
// one instance with EARLY_ZERO=1 and one with EARLY_ZERO=0.
module tb_muldiv_iter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        st [2];
  logic        bz [2];
  logic        dn [2];
  logic [31:0] rs [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int          m_left [2];
  logic [31:0] m_res  [2];
  logic [31:0] m_hold [2];

  always #5 Clk = ~Clk;

  muldiv_iter #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut_ez (
    .Clk(Clk), .Reset(Reset), .start(st[0]), .op(op_i),
    .a(a_i), .b(b_i), .busy(bz[0]), .done(dn[0]), .result(rs[0])
  );

  muldiv_iter #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_nz (
    .Clk(Clk), .Reset(Reset), .start(st[1]), .op(op_i),
    .a(a_i), .b(b_i), .busy(bz[1]), .done(dn[1]), .result(rs[1])
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, pr, qv, rv;
    longint      sa, sb;
    if (!op[2]) begin
      ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
      pr = ea * eb;
      return (op == 3'd0) ? pr[31:0] : pr[63:32];
    end
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    sa = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
    qv = sa / sb;
    rv = sa % sb;
    return op[1] ? rv[31:0] : qv[31:0];
  endfunction

  function automatic int ref_lat(input int k, input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 32'h0) return 2;
    if (!op[2] && k == 0 && (a == 32'h0 || b == 32'h0)) return 2;
    return 34;
  endfunction

  // cycle-level model: busy countdown from accept, result latched on done
  always @(posedge Clk or posedge Reset) begin
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        m_left[k] = 0;
        m_hold[k] = '0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 1) m_hold[k] = m_res[k];
      end else if (st[k]) begin
        m_res[k]  = ref_res(op_i, a_i, b_i);
        m_left[k] = ref_lat(k, op_i, a_i, b_i);
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy[%0d]", k), 64'(bz[k]), 64'(m_left[k] > 0));
        chk($sformatf("done[%0d]", k), 64'(dn[k]), 64'(m_left[k] == 1));
        chk($sformatf("result[%0d]", k), 64'(rs[k]), 64'(m_hold[k]));
      end
    end
  end

  task automatic run_op(input int k, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input bit lit,
                        input logic [31:0] lit_res, input int lit_lat);
    logic [31:0] er;
    int          el;
    int          n;
    bit          got;
    er = ref_res(op, a, b);
    el = ref_lat(k, op, a, b);
    if (lit) begin
      chk($sformatf("model_res op%0d", op), 64'(er), 64'(lit_res));
      chk($sformatf("model_lat op%0d", op), 64'(el), 64'(lit_lat));
    end
    @(negedge Clk);
    #1;
    op_i  = op;
    a_i   = a;
    b_i   = b;
    st[k] = 1'b1;
    @(posedge Clk);
    #1 st[k] = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge Clk);
      n++;
      if (dn[k]) got = 1'b1;
      else if (poke && n == 5) begin
        #1 st[k] = 1'b1;
        @(posedge Clk);
        #1 st[k] = 1'b0;
      end
    end
    chk($sformatf("done_seen op%0d", op), 64'(got), 64'd1);
    chk($sformatf("latency op%0d", op), 64'(n), 64'(el));
    chk($sformatf("final op%0d", op), 64'(rs[k]), 64'(er));
    if (poke) begin
      #1 st[k] = 1'b1;
      @(posedge Clk);
      #1 st[k] = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    st[0] = 1'b0;
    st[1] = 1'b0;
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    chk("rst_result", 64'(rs[0]), 64'd0);
    @(negedge Clk);
    #1 Reset = 1'b0;

    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFEB, 34);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1,
           32'h4000_0000, 34);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1,
           32'hFFFF_FFFE, 34);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1,
           32'hFFFF_FFFF, 34);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD, 34);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 34);
    run_op(0, 3'd5, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 34);
    run_op(0, 3'd7, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34);
    run_op(0, 3'd5, 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 2);
    run_op(0, 3'd6, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFF7, 2);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1,
           32'h8000_0000, 34);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 34);
    run_op(0, 3'd0, 32'd0, 32'd123, 1'b0, 1'b1, 32'd0, 2);
    run_op(1, 3'd0, 32'd0, 32'd123, 1'b0, 1'b1, 32'd0, 34);
    run_op(0, 3'd4, 32'd1000, 32'd3, 1'b1, 1'b1, 32'd333, 34);

    // reset in the middle of a divide
    @(negedge Clk);
    #1;
    op_i  = 3'd4;
    a_i   = 32'hFFFF_FFF9;
    b_i   = 32'd2;
    st[0] = 1'b1;
    @(posedge Clk);
    #1 st[0] = 1'b0;
    repeat (10) @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bz[0]), 64'd0);
    chk("midrst_done", 64'(dn[0]), 64'd0);
    chk("midrst_result", 64'(rs[0]), 64'd0);
    @(posedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b0;
    run_op(0, 3'd5, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 34);

    for (int i = 0; i < 200; i++) begin
      run_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             pick(), pick(), ($urandom_range(0, 7) == 0), 1'b0,
             32'h0, 0);
    end

    repeat (3) @(negedge Clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
